// File: rtl/uart_sram_loader.sv
// uart_sram_loader: receives 8N1 UART bytes, packs them low-byte-first into
// 16-bit words and writes each word to sequential SRAM addresses through a
// four-phase enable/write_done handshake until MAX_WORDS words are stored.
`timescale 1ns/1ps
module uart_sram_loader #(
   parameter int CLK_DIV   = 5208,  // clk cycles per UART bit, >= 4
   parameter int MAX_WORDS = 1024   // words to load, 1..65536
) (
   input  logic        clk,
   input  logic        rst,         // asynchronous, active-low
   input  logic        rxd,
   output logic        enable,
   output logic        writenable,
   output logic [15:0] address,
   output logic [15:0] data_write,
   input  logic        write_done,
   output logic        load_done,
   output logic [16:0] word_count,
   output logic        frame_err,
   output logic        overrun
);

   localparam int              CW        = $clog2(CLK_DIV);
   localparam logic [CW-1:0]   BIT_LAST  = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0]   HALF_LAST = CW'(CLK_DIV / 2 - 1);
   localparam logic [16:0]     LAST_WORD = 17'(MAX_WORDS - 1);

   typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
   typedef enum logic [2:0] {P_LO, P_HI, P_REQ, P_REL, P_END} pk_state_t;

   logic            rxd_meta_q, rxd_sync_q, rxd_dly_q;
   rx_state_t       rx_state_q, rx_state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic            byte_valid, frame_err_set;

   logic [7:0]      hold_q;
   logic            full_q, consume;

   pk_state_t       pk_state_q, pk_state_d;
   logic [7:0]      lo_q, lo_d;
   logic [15:0]     data_q, data_d;
   logic [15:0]     addr_q, addr_d;
   logic [16:0]     count_q, count_d;
   logic            done_q, done_d;
   logic            frame_err_q, overrun_q;

   // Two-flop synchroniser plus one delay stage for start-edge detection.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rxd_meta_q <= 1'b1;
         rxd_sync_q <= 1'b1;
         rxd_dly_q  <= 1'b1;
      end else begin
         rxd_meta_q <= rxd;
         rxd_sync_q <= rxd_meta_q;
         rxd_dly_q  <= rxd_sync_q;
      end
   end

   // Receiver next state: mid-bit sampling driven by a cycle counter.
   // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      rx_state_d    = rx_state_q;
      cnt_d         = cnt_q + 1'b1;
      bit_d         = bit_q;
      shift_d       = shift_q;
      byte_valid    = 1'b0;
      frame_err_set = 1'b0;
      case (rx_state_q)
         R_IDLE: begin
            cnt_d = '0;
            if (!rxd_sync_q && rxd_dly_q) begin
               rx_state_d = R_START;
               bit_d      = 3'd0;
            end
         end
         R_START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d      = '0;
               rx_state_d = rxd_sync_q ? R_IDLE : R_DATA;
            end
         end
         R_DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               shift_d = {rxd_sync_q, shift_q[7:1]};
               if (bit_q == 3'd7) rx_state_d = R_STOP;
               else               bit_d      = bit_q + 3'd1;
            end
         end
         R_STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d      = '0;
               rx_state_d = R_IDLE;
               if (rxd_sync_q) byte_valid    = 1'b1;
               else            frame_err_set = 1'b1;
            end
         end
         default: rx_state_d = R_IDLE;
      endcase
   end

   // Receiver state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_state_q <= R_IDLE;
         cnt_q      <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
      end else begin
         rx_state_q <= rx_state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
      end
   end

   // Packer next state: pair bytes, then run one handshake per word.
   always_comb begin
      pk_state_d = pk_state_q;
      lo_d       = lo_q;
      data_d     = data_q;
      addr_d     = addr_q;
      count_d    = count_q;
      done_d     = done_q;
      consume    = 1'b0;
      case (pk_state_q)
         P_LO: begin
            if (full_q) begin
               consume    = 1'b1;
               lo_d       = hold_q;
               pk_state_d = P_HI;
            end
         end
         P_HI: begin
            // Never raise a new request while the controller still reports done.
            if (full_q && !write_done) begin
               consume    = 1'b1;
               data_d     = {hold_q, lo_q};
               pk_state_d = P_REQ;
            end
         end
         P_REQ: begin
            if (write_done) pk_state_d = P_REL;
         end
         P_REL: begin
            if (!write_done) begin
               addr_d  = addr_q + 16'd1;
               count_d = count_q + 17'd1;
               if (count_q == LAST_WORD) begin
                  done_d     = 1'b1;
                  pk_state_d = P_END;
               end else begin
                  pk_state_d = P_LO;
               end
            end
         end
         P_END: consume = full_q;  // drain and discard late bytes
         default: pk_state_d = P_LO;
      endcase
   end

   // Packer, holding register and sticky status flags.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pk_state_q  <= P_LO;
         lo_q        <= '0;
         data_q      <= '0;
         addr_q      <= '0;
         count_q     <= '0;
         done_q      <= 1'b0;
         hold_q      <= '0;
         full_q      <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         pk_state_q <= pk_state_d;
         lo_q       <= lo_d;
         data_q     <= data_d;
         addr_q     <= addr_d;
         count_q    <= count_d;
         done_q     <= done_d;
         // A consume and a new byte in the same cycle leave the register full
         // with the new byte and do not count as an overrun.
         full_q     <= (full_q & ~consume) | byte_valid;
         if (byte_valid) hold_q <= shift_d;
         if (byte_valid && full_q && !consume) overrun_q <= 1'b1;
         if (frame_err_set) frame_err_q <= 1'b1;
      end
   end

   // Request strobes are a pure decode of the registered packer state.
   assign enable     = (pk_state_q == P_REQ);
   assign writenable = (pk_state_q == P_REQ);
   assign address    = addr_q;
   assign data_write = data_q;
   assign load_done  = done_q;
   assign word_count = count_q;
   assign frame_err  = frame_err_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_sram_loader.sv
// Directed bench for uart_sram_loader: a byte-level model predicts every
// SRAM write; a per-cycle monitor compares requests against it.
`timescale 1ns/1ps
module tb_uart_sram_loader;

   localparam int CLK_DIV   = 16;
   localparam int MAX_WORDS = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rxd = 1'b1;
   logic        write_done = 1'b0;
   logic        enable, writenable, load_done, frame_err, overrun;
   logic [15:0] address, data_write;
   logic [16:0] word_count;

   uart_sram_loader #(.CLK_DIV(CLK_DIV), .MAX_WORDS(MAX_WORDS)) dut (
      .clk        (clk),
      .rst        (rst),
      .rxd        (rxd),
      .enable     (enable),
      .writenable (writenable),
      .address    (address),
      .data_write (data_write),
      .write_done (write_done),
      .load_done  (load_done),
      .word_count (word_count),
      .frame_err  (frame_err),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] addr;
      logic [15:0] data;
   } wr_t;

   int   n_checks = 0;
   int   n_errors = 0;
   bit   stall    = 1'b0;

   // Model state: expected writes in order, plus pairing/counting.
   wr_t         exp_q[$];
   bit          m_have_lo;
   logic [7:0]  m_lo;
   logic [15:0] m_addr;
   int          m_words;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_have_lo = 1'b0;
      m_lo      = 8'h00;
      m_addr    = 16'h0000;
      m_words   = 0;
   endtask

   task automatic model_byte(input logic [7:0] b);
      if (m_words >= MAX_WORDS) return;
      if (!m_have_lo) begin
         m_lo      = b;
         m_have_lo = 1'b1;
      end else begin
         exp_q.push_back('{addr: m_addr, data: {b, m_lo}});
         m_addr    = m_addr + 16'd1;
         m_words++;
         m_have_lo = 1'b0;
      end
   endtask

   task automatic drive_bit(input logic v);
      #1 rxd = v;
      repeat (CLK_DIV) @(posedge clk);
   endtask

   // One frame: start, 8 data LSB first, stop, then one idle bit.
   task automatic send_byte(input logic [7:0] b, input logic stop, input bit keep);
      if (keep) model_byte(b);
      @(posedge clk);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
      drive_bit(stop);
      drive_bit(1'b1);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("rst_enable",     enable,     0);
      check("rst_writenable", writenable, 0);
      check("rst_address",    address,    0);
      check("rst_data",       data_write, 0);
      check("rst_load_done",  load_done,  0);
      check("rst_word_count", word_count, 0);
      check("rst_frame_err",  frame_err,  0);
      check("rst_overrun",    overrun,    0);
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   // Wait until all predicted writes were requested and the handshake settled.
   task automatic wait_idle(input string tag);
      bit ok = 1'b0;
      for (int k = 0; k < 600 && !ok; k++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !enable && !write_done) ok = 1'b1;
      end
      if (!ok) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s_timeout: pending=%0d enable=%0b expected idle", tag, exp_q.size(), enable);
      end
      repeat (4) @(negedge clk);
      check({tag, "_word_count"}, word_count, m_words);
      check({tag, "_load_done"},  load_done,  (m_words == MAX_WORDS));
   endtask

   // SRAM controller model: done 3 cycles after enable, held 5 cycles.
   initial begin
      forever begin
         @(negedge clk);
         if (enable) begin
            while (stall) @(negedge clk);
            repeat (3) @(posedge clk);
            #1 write_done = 1'b1;
            repeat (5) @(posedge clk);
            #1 write_done = 1'b0;
            while (enable) @(negedge clk);
         end
      end
   end

   // Per-cycle monitor.
   initial begin
      logic prev_en = 1'b0;
      wr_t  cur = '0;
      wr_t  e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            prev_en = 1'b0;
         end else begin
            check("we_tracks_en", writenable, enable);
            if (enable && !prev_en) begin
               check("req_while_done", write_done, 0);
               cur = '{addr: address, data: data_write};
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL unexpected_req: got addr=0x%0h data=0x%0h expected no request", address, data_write);
               end else begin
                  e = exp_q.pop_front();
                  check("req_addr", address,    e.addr);
                  check("req_data", data_write, e.data);
               end
            end else if (enable) begin
               check("hold_addr", address,    cur.addr);
               check("hold_data", data_write, cur.data);
            end
            prev_en = enable;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [16:0] snap_cnt;
      logic [15:0] snap_addr;
      bit          seen;
      model_reset();

      // 1: single word 0x1234 at address 0.
      do_reset();
      send_byte(8'h34, 1'b1, 1'b1);
      send_byte(8'h12, 1'b1, 1'b1);
      wait_idle("t1");
      check("t1_count_lit", word_count, 1);
      check("t1_addr_lit",  address,    1);
      check("t1_data_lit",  data_write, 16'h1234);

      // 2: fill to MAX_WORDS, then late bytes are ignored.
      do_reset();
      for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b1, 1'b1);
      wait_idle("t2");
      check("t2_done_lit",  load_done,  1);
      check("t2_count_lit", word_count, 4);
      check("t2_addr_lit",  address,    4);
      check("t2_data_lit",  data_write, 16'h0807);
      send_byte(8'h09, 1'b1, 1'b1);
      send_byte(8'h0A, 1'b1, 1'b1);
      wait_idle("t2b");
      check("t2_no_overrun", overrun, 0);

      // 3: framing error drops the byte.
      do_reset();
      send_byte(8'h55, 1'b0, 1'b0);
      send_byte(8'h66, 1'b1, 1'b1);
      send_byte(8'h77, 1'b1, 1'b1);
      wait_idle("t3");
      check("t3_frame_err", frame_err,  1);
      check("t3_data_lit",  data_write, 16'h7766);
      check("t3_addr_lit",  address,    1);

      // 5: short glitch produces no byte.
      snap_cnt  = word_count;
      snap_addr = address;
      @(posedge clk);
      #1 rxd = 1'b0;
      repeat (CLK_DIV / 4) @(posedge clk);
      #1 rxd = 1'b1;
      repeat (3 * CLK_DIV) @(posedge clk);
      send_byte(8'hA5, 1'b1, 1'b1);  // a lone low byte: stays unpaired
      wait_idle("t5");
      check("t5_count", word_count, snap_cnt);
      check("t5_addr",  address,    snap_addr);
      check("t5_ovr",   overrun,    0);

      // 4: stalled handshake, two bytes arrive, second overwrites first.
      do_reset();
      stall = 1'b1;
      send_byte(8'hAA, 1'b1, 1'b1);
      send_byte(8'hBB, 1'b1, 1'b1);
      send_byte(8'hC1, 1'b1, 1'b0);
      check("t4_no_ovr_yet", overrun, 0);
      send_byte(8'hC2, 1'b1, 1'b1);
      check("t4_overrun",   overrun, 1);
      check("t4_en_high",   enable,  1);
      repeat (10 * CLK_DIV) @(posedge clk);
      check("t4_en_still",  enable,  1);
      stall = 1'b0;
      send_byte(8'hC3, 1'b1, 1'b1);
      wait_idle("t4");
      check("t4_data_lit", data_write, 16'hC3C2);
      check("t4_addr_lit", address,    2);

      // 6: reset during a pending request.
      do_reset();
      stall = 1'b1;
      send_byte(8'h11, 1'b1, 1'b1);
      send_byte(8'h22, 1'b1, 1'b1);
      seen = 1'b0;
      for (int k = 0; k < 100 && !seen; k++) begin
         @(negedge clk);
         if (enable) seen = 1'b1;
      end
      check("t6_req_seen", seen, 1);
      do_reset();
      stall = 1'b0;
      send_byte(8'h33, 1'b1, 1'b1);
      send_byte(8'h44, 1'b1, 1'b1);
      wait_idle("t6");
      check("t6_data_lit", data_write, 16'h4433);
      check("t6_addr_lit", address,    1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_sram_loader.md
Name: uart_sram_loader

Overview:
- Upstream feeder for the SRAM controller in the uart2sram design.
- Receives 8N1 UART bytes on rxd and packs byte pairs, low byte first, into 16-bit words.
- Issues one SRAM write request per word at sequential addresses from 0, using the controller's enable/writenable/address/data_write/write_done handshake.
- Stops after MAX_WORDS words and flags load complete.

Parameters:
- CLK_DIV, 5208, clk cycles per UART bit (50 MHz / 9600); must be ≥ 4.
- MAX_WORDS, 1024, words to load before load_done; range 1..65536.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- rxd  in  1  UART serial input, idle high, asynchronous to clk
- enable  out  1  SRAM request valid
- writenable  out  1  SRAM write select; also drives the SRAM data bus via the controller
- address  out  16  SRAM word address
- data_write  out  16  word to write, {high byte, low byte}
- write_done  in  1  SRAM controller write-complete level
- load_done  out  1  sticky; MAX_WORDS words written
- word_count  out  17  number of words written so far
- frame_err  out  1  sticky; stop bit sampled low
- overrun  out  1  sticky; byte completed while holding register still full

Behaviour:
- Reset values (rst=0, asynchronous): enable=0, writenable=0, address=0, data_write=0, load_done=0, word_count=0, frame_err=0, overrun=0.
- Reset mid-operation: RX FSM returns to R_IDLE, packer FSM returns to P_LO, any partial byte or word is discarded.
- rxd passes through a 2-flop synchroniser, reset to 1. Only the synchronised signal is used.
- RX FSM states:
  - R_IDLE: on a synchronised 1→0 edge, go to R_START with bit counter = 0.
  - R_START: at CLK_DIV/2 cycles, sample. If high (glitch), return to R_IDLE. If low, go to R_DATA.
  - R_DATA: sample every CLK_DIV cycles, 8 bits, LSB first.
  - R_STOP: sample after CLK_DIV cycles.
    - Sample 1: assert a 1-cycle byte_valid strobe with the byte.
    - Sample 0: set frame_err and drop the byte.
    - Either way, return to R_IDLE.
- Byte holding register: byte_valid loads it and sets its full flag; the packer clears the flag when it consumes the byte. If byte_valid arrives while the flag is set, set overrun; the new byte overwrites the old one.
- Packer FSM states:
  - P_LO: consume a byte into lo.
  - P_HI: consume a byte into hi, latch data_write={hi,lo}, go to P_REQ.
  - P_REQ: enable=1 and writenable=1, with address and data_write held stable. Stay until write_done=1 is seen.
  - P_REL: in the cycle after write_done is seen, drop enable and writenable. Keep address stable. Wait for write_done=0. Then:
    - address += 1, word_count += 1.
    - If word_count reaches MAX_WORDS, set load_done and go to P_END; otherwise go to P_LO.
  - P_END: terminal. Bytes are still received but ignored; overrun is not flagged. Only reset exits.
- enable and writenable always change together. writenable is never 1 while enable is 0.
- Four-phase handshake: a new request is never raised while write_done=1.
- Latency: enable rises 2 clk cycles after the stop-bit sample of the second byte (byte_valid, then P_HI latch).
- address wraps naturally at 0xFFFF→0 only when MAX_WORDS=65536; load_done fires in the same step.
- Simultaneous byte_valid and consume in one cycle: the consume takes effect first, the new byte loads, and no overrun is flagged.
- A byte that arrives while the packer is in P_REQ or P_REL waits in the holding register.

Test Plan (CLK_DIV=16, MAX_WORDS=4, SRAM model asserts write_done 3 cycles after enable and holds it 5 cycles):
- Send 0x34 then 0x12 → one request with address=0, data_write=0x1234, enable=writenable=1 until write_done; afterwards word_count=1, address=1.
- Send 8 bytes 0x01..0x08 → writes 0x0201@0, 0x0403@1, 0x0605@2, 0x0807@3; load_done=1, word_count=4; a 9th byte causes no request.
- Byte 0x55 with stop bit forced 0, then 0x66, 0x77 → frame_err=1; one write of 0x7766 at address 0.
- Hold write_done=0 for 3 byte times after a word; send 2 more bytes → overrun=1, enable stays high, no second request until the handshake completes.
- 0.25-bit low glitch on rxd, then idle → no byte_valid, outputs unchanged.
- Assert rst during P_REQ → enable, writenable, address and word_count go to 0 immediately; the next two bytes write to address 0.
